// File: rtl/match_pkg.sv
// Shared types and constants for the best-of-N match sequencer.
// State encoding, default match parameters, and a parameter sanity helper.
// No logic; imported by match_sequencer and gap_timer.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_ROUNDS_TO_WIN = 3;
  localparam int DEF_GAP_TICKS     = 64;
  localparam int TIMER_W           = 8;

  // True when a cnt_w-bit unsigned counter can hold the value rounds.
  function automatic bit cnt_fits(input int cnt_w, input int rounds);
    return (cnt_w >= 1) && (cnt_w < 31) && (rounds < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Intermission timer: 8-bit loadable down-counter advanced by slowen while enabled.
// done is combinational, high in the single cycle whose slowen takes the count 1 -> 0.
// No backpressure; load has priority over a coincident slowen, so that tick is not counted.
module gap_timer
  import match_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  input  logic               slowen,
  output logic               done
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down on slowen and flag the final tick.
  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en && slowen && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      done  = (cnt_q == TIMER_W'(1));
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/match_sequencer.sv
// Best-of-N Tug-of-War match controller: starts rounds, tallies wins, times intermissions.
// All outputs registered; a triggering input in cycle N is reflected in cycle N+1.
// No backpressure; inputs not meaningful in the current state are dropped.
module match_sequencer
  import match_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slowen,
  input  logic             start,
  input  logic             winrnd,
  input  logic             right,
  input  logic             tie,
  output logic             round_go,
  output logic             clear,
  output logic [CNT_W-1:0] l_wins,
  output logic [CNT_W-1:0] r_wins,
  output logic             show_tally,
  output logic             match_over,
  output logic             match_winner,
  output logic             sound_en
);

  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 7) begin : g_bad_rounds
    $error("match_sequencer: ROUNDS_TO_WIN must be 1..7");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap
    $error("match_sequencer: GAP_TICKS must be 1..255");
  end
  if (!cnt_fits(CNT_W, ROUNDS_TO_WIN)) begin : g_bad_cnt_w
    $error("match_sequencer: CNT_W too narrow for ROUNDS_TO_WIN");
  end

  localparam logic [CNT_W-1:0]   WIN_CNT  = CNT_W'(ROUNDS_TO_WIN);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_TICKS);

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             arm_q, arm_d;
  logic             start_edge;
  logic [CNT_W-1:0] l_wins_q, l_wins_d, r_wins_q, r_wins_d;
  logic [CNT_W-1:0] l_inc, r_inc;
  logic             round_go_q, round_go_d, clear_q, clear_d;
  logic             show_tally_q, show_tally_d, match_over_q, match_over_d;
  logic             match_winner_q, match_winner_d, sound_en_q, sound_en_d;
  logic             tmr_load, tmr_done;

  // Start edge; arm_q stays low until start is seen released after reset,
  // so a button held through reset cannot launch a match.
  always_comb begin
    start_d    = start;
    arm_d      = arm_q | ~start;
    start_edge = start & ~start_q & arm_q;
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d        = state_q;
    l_wins_d       = l_wins_q;
    r_wins_d       = r_wins_q;
    match_winner_d = match_winner_q;
    round_go_d     = 1'b0;
    clear_d        = 1'b0;
    l_inc          = l_wins_q + 1'b1;
    r_inc          = r_wins_q + 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          l_wins_d       = '0;
          r_wins_d       = '0;
          match_winner_d = 1'b0;
          round_go_d     = 1'b1;
          clear_d        = 1'b1;
          state_d        = PLAY;
        end
      end
      PLAY: begin
        if (winrnd) begin
          state_d = GAP;
          if (!tie) begin
            if (right) begin
              r_wins_d = r_inc;
              if (r_inc == WIN_CNT) begin
                state_d        = DONE;
                match_winner_d = 1'b1;
              end
            end else begin
              l_wins_d = l_inc;
              if (l_inc == WIN_CNT) begin
                state_d        = DONE;
                match_winner_d = 1'b0;
              end
            end
          end
        end
      end
      GAP: begin
        if (tmr_done) begin
          round_go_d = 1'b1;
          clear_d    = 1'b1;
          state_d    = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
    tmr_load     = (state_q == PLAY) && (state_d == GAP);
    show_tally_d = (state_d == GAP) || (state_d == DONE);
    match_over_d = (state_d == DONE);
    sound_en_d   = (state_d == DONE);
  end

  gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .en       (state_q == GAP),
    .slowen   (slowen),
    .done     (tmr_done)
  );

  // State and output registers; reset squashes any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      arm_q          <= 1'b0;
      l_wins_q       <= '0;
      r_wins_q       <= '0;
      round_go_q     <= 1'b0;
      clear_q        <= 1'b0;
      show_tally_q   <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= 1'b0;
      sound_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      arm_q          <= arm_d;
      l_wins_q       <= l_wins_d;
      r_wins_q       <= r_wins_d;
      round_go_q     <= round_go_d;
      clear_q        <= clear_d;
      show_tally_q   <= show_tally_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
      sound_en_q     <= sound_en_d;
    end
  end

  assign round_go     = round_go_q;
  assign clear        = clear_q;
  assign l_wins       = l_wins_q;
  assign r_wins       = r_wins_q;
  assign show_tally   = show_tally_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign sound_en     = sound_en_q;

endmodule
